mmio_uart_tx: RTL and testbench

Memory-mapped UART transmitter hanging off the single-cycle core's data port, beside the data memory. It consumes the core's store traffic (MemWrite, DataAdr, WriteData) in its address window, buffers bytes in a FIFO, and serialises them 8N1 on `txd`. A combinational status register is returned on the read-data path so software can poll with `lw`.

---
 rtl/mmio_uart_tx.sv | 169 ++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA/STATUS word pair, byte FIFO, serialiser.
module mmio_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0400
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        sel,
  output logic        txd,
  output logic        busy
);

  localparam int unsigned PW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CNTW = PW + 1;
  localparam int unsigned CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [7:0]      mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CNTW-1:0] count;
  logic            empty, full, push, pop;
  logic            wr_data, wr_stat, overflow;
  logic [7:0]      head;

  logic [1:0]      state, state_n;
  logic [CW-1:0]   bit_cnt, bit_cnt_n;
  logic [2:0]      bit_idx, bit_idx_n;
  logic [7:0]      shift, shift_n;
  logic            txd_n, busy_n, bit_end;

  // a[1:0] and wd[31:8] carry no meaning for this peripheral
  logic unused_bits;
  assign unused_bits = ^{a[1:0], wd[31:8]};

  // Address decode and FIFO status
  assign sel     = (a[31:3] == BASE_ADDR[31:3]);
  assign wr_data = we & sel & ~a[2];
  assign wr_stat = we & sel & a[2];
  assign empty   = (count == '0);
  assign full    = (count == CNTW'(FIFO_DEPTH));
  assign push    = wr_data & ~full;
  assign head    = mem[rd_ptr];

  // Combinational STATUS read path
  always_comb begin
    rd = '0;
    if (sel & a[2]) rd = {28'b0, overflow, busy, empty, full};
  end

  // FIFO storage; contents are don't-care once pointers reset
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wd[7:0];
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CNTW'(1);
        2'b01:   count <= count - CNTW'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow: a store to a full FIFO is dropped even if a pop coincides
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                overflow <= 1'b0;
    else if (wr_data && full) overflow <= 1'b1;
    else if (wr_stat && wd[3]) overflow <= 1'b0;
  end

  // Serialiser state register; txd/busy registered from next-state values
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      bit_cnt <= '0;
      bit_idx <= '0;
      shift   <= '0;
      txd     <= 1'b1;
      busy    <= 1'b0;
    end else begin
      state   <= state_n;
      bit_cnt <= bit_cnt_n;
      bit_idx <= bit_idx_n;
      shift   <= shift_n;
      txd     <= txd_n;
      busy    <= busy_n;
    end
  end

  // Serialiser next-state and pop logic
  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    bit_idx_n = bit_idx;
    shift_n   = shift;
    pop       = 1'b0;
    bit_end   = (bit_cnt == CW'(CLKS_PER_BIT - 1));

    case (state)
      S_IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          shift_n   = head;
          bit_cnt_n = '0;
          state_n   = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          bit_cnt_n = '0;
          bit_idx_n = '0;
          state_n   = S_DATA;
        end else begin
          bit_cnt_n = bit_cnt + CW'(1);
        end
      end
      S_DATA: begin
        if (bit_end) begin
          bit_cnt_n = '0;
          shift_n   = {1'b0, shift[7:1]};
          if (bit_idx == 3'd7) state_n = S_STOP;
          else                 bit_idx_n = bit_idx + 3'd1;
        end else begin
          bit_cnt_n = bit_cnt + CW'(1);
        end
      end
      S_STOP: begin
        if (bit_end) begin
          bit_cnt_n = '0;
          if (!empty) begin
            pop     = 1'b1;
            shift_n = head;
            state_n = S_START;
          end else begin
            state_n = S_IDLE;
          end
        end else begin
          bit_cnt_n = bit_cnt + CW'(1);
        end
      end
      default: state_n = S_IDLE;
    endcase

    case (state_n)
      S_START: txd_n = 1'b0;
      S_DATA:  txd_n = shift_n[0];
      default: txd_n = 1'b1;
    endcase
    busy_n = (state_n != S_IDLE);
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=8.
module tb_mmio_uart_tx;

  localparam int          CPB  = 4;
  localparam logic [31:0] BASE = 32'h0000_0400;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        we = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] wd = '0;
  logic [31:0] rd;
  logic        sel, txd, busy;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int rst_cnt = 0;
  logic [7:0] rx_q[$];
  int         rx_start_q[$];

  mmio_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(8), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .we(we), .a(a), .wd(wd),
    .rd(rd), .sel(sel), .txd(txd), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge reset) rst_cnt++;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  // Line monitor: detects the first low cycle of a start bit, samples mid-bit
  initial begin
    logic [7:0] b;
    int st, rc;
    forever begin
      @(posedge clk); #2;
      if (!reset && txd === 1'b0) begin
        st = cyc; rc = rst_cnt; b = '0;
        repeat (CPB/2) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(posedge clk);
          #2 b[i] = txd;
        end
        repeat (CPB) @(posedge clk);
        #2;
        if (rc == rst_cnt && !reset) begin
          rx_q.push_back(b);
          rx_start_q.push_back(st);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic wait_rx(input int n, input int limit, output bit ok);
    for (int i = 0; i < limit && rx_q.size() < n; i++) tick();
    ok = (rx_q.size() == n);
  endtask

  task automatic wait_idle(input int limit, output bit ok);
    a = BASE + 32'd4;
    for (int i = 0; i < limit; i++) begin
      tick(); #1;
      if (rd === 32'h2) break;
    end
    ok = (rd === 32'h2);
  endtask

  task automatic test_reset;
    reset = 1'b1; we = 1'b0;
    tick(); tick();
    a = BASE + 32'd4; #1;
    n_cmp++; if (txd !== 1'b1) begin n_bad++; $display("FAIL reset_txd: got %b want 1", txd); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (rd !== 32'h2) begin n_bad++; $display("FAIL reset_status: got %h want 00000002", rd); end
    n_cmp++; if (sel !== 1'b1) begin n_bad++; $display("FAIL reset_sel_status: got %b want 1", sel); end
    a = BASE + 32'd7; #1;
    n_cmp++; if (rd !== 32'h2) begin n_bad++; $display("FAIL status_low_bits_ignored: got %h want 00000002", rd); end
    a = BASE - 32'd4; #1;
    n_cmp++; if (sel !== 1'b0) begin n_bad++; $display("FAIL sel_below: got %b want 0", sel); end
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL rd_below: got %h want 00000000", rd); end
    a = BASE + 32'd8; #1;
    n_cmp++; if (sel !== 1'b0) begin n_bad++; $display("FAIL sel_above: got %b want 0", sel); end
    tick(); reset = 1'b0;
    tick();
  endtask

  task automatic test_single_byte;
    logic lvl [10];
    lvl = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    tick(); we = 1'b1; a = BASE; wd = 32'h1234_56A5;
    tick(); we = 1'b0; a = BASE + 32'd4; #1;
    n_cmp++; if (txd !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL single_t1_line: got txd=%b busy=%b want 1/0", txd, busy); end
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL single_t1_status: got %h want 00000000", rd); end
    for (int k = 2; k <= 41; k++) begin
      tick();
      n_cmp++;
      if (txd !== lvl[(k-2)/CPB] || busy !== 1'b1) begin
        n_bad++;
        $display("FAIL single_frame t+%0d: got txd=%b busy=%b want %b/1", k, txd, busy, lvl[(k-2)/CPB]);
      end
    end
    tick(); #1;
    n_cmp++; if (busy !== 1'b0 || txd !== 1'b1) begin n_bad++; $display("FAIL single_end t+42: got busy=%b txd=%b want 0/1", busy, txd); end
    n_cmp++; if (rd !== 32'h2) begin n_bad++; $display("FAIL single_end_status: got %h want 00000002", rd); end
    tick();
    rx_q.delete(); rx_start_q.delete();
  endtask

  task automatic test_overflow;
    bit ok;
    rx_q.delete(); rx_start_q.delete();
    for (int i = 0; i < 10; i++) begin
      tick(); we = 1'b1; a = BASE; wd = 32'hDEAD_0030 + 32'(i);
    end
    tick(); a = BASE + 32'd4; wd = 32'h8; #1;
    n_cmp++; if (rd !== 32'hD) begin n_bad++; $display("FAIL overflow_status: got %h want 0000000d", rd); end
    tick(); we = 1'b0; #1;
    n_cmp++; if (rd !== 32'h5) begin n_bad++; $display("FAIL overflow_cleared: got %h want 00000005", rd); end
    wait_rx(9, 9*10*CPB + 40, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL overflow_rx_count: got %0d want 9", rx_q.size()); end
    if (ok) begin
      for (int i = 0; i < 9; i++) begin
        n_cmp++;
        if (rx_q[i] !== 8'h30 + 8'(i)) begin n_bad++; $display("FAIL overflow_byte[%0d]: got %h want %h", i, rx_q[i], 8'h30 + 8'(i)); end
      end
    end
    wait_idle(20, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL overflow_drain: got %h want 00000002", rd); end
  endtask

  task automatic test_back_to_back;
    bit ok;
    rx_q.delete(); rx_start_q.delete();
    tick(); we = 1'b1; a = BASE; wd = 32'h0000_0000;
    tick(); wd = 32'h0000_00FF;
    tick(); we = 1'b0;
    wait_rx(2, 2*10*CPB + 40, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL b2b_rx_count: got %0d want 2", rx_q.size()); end
    if (ok) begin
      n_cmp++; if (rx_q[0] !== 8'h00) begin n_bad++; $display("FAIL b2b_byte0: got %h want 00", rx_q[0]); end
      n_cmp++; if (rx_q[1] !== 8'hFF) begin n_bad++; $display("FAIL b2b_byte1: got %h want ff", rx_q[1]); end
      n_cmp++;
      if (rx_start_q[1] - rx_start_q[0] !== 10*CPB) begin
        n_bad++; $display("FAIL b2b_gap: got %0d cycles want %0d", rx_start_q[1] - rx_start_q[0], 10*CPB);
      end
    end
    wait_idle(20, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL b2b_drain: got %h want 00000002", rd); end
  endtask

  task automatic test_pointer_wrap;
    bit ok;
    logic [7:0] exp_b [20];
    int idx, len;
    for (int i = 0; i < 20; i++) exp_b[i] = 8'(i*37 + 11);
    rx_q.delete(); rx_start_q.delete();
    idx = 0;
    for (int b = 0; b < 3; b++) begin
      len = (b == 2) ? 6 : 7;
      for (int j = 0; j < len; j++) begin
        tick(); we = 1'b1; a = BASE; wd = {24'hA5A5A5, exp_b[idx]};
        idx++;
      end
      tick(); we = 1'b0;
      wait_rx(idx, len*10*CPB + 60, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL wrap_burst%0d_count: got %0d want %0d", b, rx_q.size(), idx); end
      wait_idle(20, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL wrap_burst%0d_drain: got %h want 00000002", b, rd); end
    end
    n_cmp++; if (rx_q.size() != 20) begin n_bad++; $display("FAIL wrap_total: got %0d want 20", rx_q.size()); end
    for (int i = 0; i < 20 && i < rx_q.size(); i++) begin
      n_cmp++;
      if (rx_q[i] !== exp_b[i]) begin n_bad++; $display("FAIL wrap_byte[%0d]: got %h want %h", i, rx_q[i], exp_b[i]); end
    end
  endtask

  task automatic test_reset_mid_frame;
    bit low_seen;
    rx_q.delete(); rx_start_q.delete();
    tick(); we = 1'b1; a = BASE; wd = 32'h55;
    tick(); wd = 32'h0F;
    tick(); wd = 32'hF0;
    tick(); we = 1'b0; a = BASE + 32'd4;
    repeat (16) tick();
    #1;
    n_cmp++; if (txd !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL midframe_bit3: got txd=%b busy=%b want 0/1", txd, busy); end
    reset = 1'b1; #1;
    n_cmp++; if (txd !== 1'b1) begin n_bad++; $display("FAIL midframe_reset_txd: got %b want 1", txd); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midframe_reset_busy: got %b want 0", busy); end
    n_cmp++; if (rd !== 32'h2) begin n_bad++; $display("FAIL midframe_reset_status: got %h want 00000002", rd); end
    tick(); tick(); reset = 1'b0;
    low_seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (txd !== 1'b1) low_seen = 1'b1;
    end
    n_cmp++; if (low_seen) begin n_bad++; $display("FAIL midframe_line_quiet: got activity want idle line"); end
    n_cmp++; if (rx_q.size() != 0) begin n_bad++; $display("FAIL midframe_no_frames: got %0d want 0", rx_q.size()); end
    #1;
    n_cmp++; if (rd !== 32'h2) begin n_bad++; $display("FAIL midframe_final_status: got %h want 00000002", rd); end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_overflow();
    test_back_to_back();
    test_pointer_wrap();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
